// File: rtl/key_debounce.sv
// Two-flop synchronizer and per-key stability-counter debouncer for active-low push buttons.
// Produces a clean level bus plus one-cycle press/release strobes.
module key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw_n,
  output logic [WIDTH-1:0] key_state_n,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_pressed
);

  typedef enum logic {
    STABLE,
    PENDING
  } key_phase_t;

  localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     sync1;
  logic [WIDTH-1:0]     sync2;
  logic [CNT_WIDTH-1:0] cnt      [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_next [WIDTH];
  key_phase_t           phase    [WIDTH];
  logic [WIDTH-1:0]     commit;
  logic [WIDTH-1:0]     state_next;
  logic [WIDTH-1:0]     press_next;
  logic [WIDTH-1:0]     release_next;
  logic                 any_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= '1;
      sync2         <= '1;
      key_state_n   <= '1;
      press_pulse   <= '0;
      release_pulse <= '0;
      any_pressed   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1         <= key_raw_n;
      sync2         <= sync1;
      key_state_n   <= state_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      any_pressed   <= any_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // A key is PENDING while its synchronized input disagrees with the accepted level;
  // any agreement drops it back to STABLE and discards the partial count.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      phase[i]    = (sync2[i] != key_state_n[i]) ? PENDING : STABLE;
      commit[i]   = 1'b0;
      cnt_next[i] = '0;
      case (phase[i])
        STABLE: begin
          cnt_next[i] = '0;
        end
        PENDING: begin
          if (cnt[i] == TERMINAL) begin
            commit[i]   = 1'b1;
            cnt_next[i] = '0;
          end else begin
            cnt_next[i] = cnt[i] + CNT_ONE;
          end
        end
        default: begin
          cnt_next[i] = '0;
        end
      endcase
    end
    state_next = (key_state_n & ~commit) | (sync2 & commit);
  end

  always_comb begin
    press_next   = commit & ~sync2;
    release_next = commit & sync2;
    any_next     = |(~state_next);
  end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus pushes expected strobe events, monitors pop and compare.
// A second instance built with DEBOUNCE_CYCLES=1 covers the minimum-latency case.
module tb_key_debounce;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] state;
    logic       any;
  } event_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw_n;
  logic [3:0] key_state_n;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic       any_pressed;

  logic [3:0] raw1;
  logic [3:0] state1;
  logic [3:0] press1;
  logic [3:0] rel1;
  logic       any1;

  int     cyc    = 0;
  int     checks = 0;
  int     errors = 0;
  event_t sb0 [$];
  event_t sb1 [$];
  event_t ev0;
  event_t ev1;
  int     n;

  key_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .key_raw_n(key_raw_n), .key_state_n(key_state_n),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .any_pressed(any_pressed)
  );

  key_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .key_raw_n(raw1), .key_state_n(state1),
    .press_pulse(press1), .release_pulse(rel1), .any_pressed(any1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive the raw pins at a falling edge and hold them for the given number of cycles.
  task automatic applyStimulus(input logic [3:0] raw, input int cycles);
    key_raw_n = raw;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic expectEvent(input int at, input logic [3:0] press, input logic [3:0] rel,
                             input logic [3:0] state, input logic any);
    event_t e;
    e.cyc = at; e.press = press; e.rel = rel; e.state = state; e.any = any;
    sb0.push_back(e);
  endtask

  task automatic holdReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    checkOutput("reset key_state_n", int'(key_state_n), 'hF);
    checkOutput("reset pulses", int'({press_pulse, release_pulse}), 0);
    checkOutput("reset any_pressed", int'(any_pressed), 0);
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && ((press_pulse | release_pulse) != 4'h0)) begin
      if (sb0.size() == 0) begin
        checkOutput("dut unexpected pulse", int'({press_pulse, release_pulse}), 0);
      end else begin
        ev0 = sb0.pop_front();
        checkOutput("dut event cycle", cyc, ev0.cyc);
        checkOutput("dut press_pulse", int'(press_pulse), int'(ev0.press));
        checkOutput("dut release_pulse", int'(release_pulse), int'(ev0.rel));
        checkOutput("dut key_state_n", int'(key_state_n), int'(ev0.state));
        checkOutput("dut any_pressed", int'(any_pressed), int'(ev0.any));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && ((press1 | rel1) != 4'h0)) begin
      if (sb1.size() == 0) begin
        checkOutput("dut1 unexpected pulse", int'({press1, rel1}), 0);
      end else begin
        ev1 = sb1.pop_front();
        checkOutput("dut1 event cycle", cyc, ev1.cyc);
        checkOutput("dut1 press_pulse", int'(press1), int'(ev1.press));
        checkOutput("dut1 release_pulse", int'(rel1), int'(ev1.rel));
        checkOutput("dut1 key_state_n", int'(state1), int'(ev1.state));
        checkOutput("dut1 any_pressed", int'(any1), int'(ev1.any));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    event_t e;
    reset     = 1'b1;
    key_raw_n = 4'hF;
    raw1      = 4'hF;
    @(negedge clk);
    holdReset(3);

    applyStimulus(4'hF, 20);
    checkOutput("idle key_state_n", int'(key_state_n), 'hF);
    checkOutput("idle any_pressed", int'(any_pressed), 0);

    // Key 0 press: commit lands 10 edges after the falling edge that drove it.
    n = cyc;
    expectEvent(n + 10, 4'h1, 4'h0, 4'hE, 1'b1);
    applyStimulus(4'hE, 9);
    checkOutput("pre-commit key_state_n", int'(key_state_n), 'hF);
    checkOutput("pre-commit any_pressed", int'(any_pressed), 0);
    applyStimulus(4'hE, 6);
    checkOutput("held key_state_n", int'(key_state_n), 'hE);
    checkOutput("held any_pressed", int'(any_pressed), 1);
    checkOutput("held press_pulse", int'(press_pulse), 0);
    n = cyc;
    expectEvent(n + 10, 4'h0, 4'h1, 4'hF, 1'b0);
    applyStimulus(4'hF, 20);

    // Bounce on key 1 never stays low long enough to commit.
    applyStimulus(4'hD, 5);
    applyStimulus(4'hF, 2);
    applyStimulus(4'hD, 3);
    applyStimulus(4'hF, 20);
    checkOutput("bounce key_state_n", int'(key_state_n), 'hF);

    // Keys 2 and 3 together.
    n = cyc;
    expectEvent(n + 10, 4'hC, 4'h0, 4'h3, 1'b1);
    applyStimulus(4'h3, 20);
    n = cyc;
    expectEvent(n + 10, 4'h0, 4'hC, 4'hF, 1'b0);
    applyStimulus(4'hF, 20);
    checkOutput("dual release key_state_n", int'(key_state_n), 'hF);

    // Key 0 held through a mid-count reset and through a post-commit reset.
    applyStimulus(4'hE, 4);
    holdReset(3);
    n = cyc;
    expectEvent(n + 10, 4'h1, 4'h0, 4'hE, 1'b1);
    applyStimulus(4'hE, 15);
    holdReset(3);
    n = cyc;
    expectEvent(n + 10, 4'h1, 4'h0, 4'hE, 1'b1);
    applyStimulus(4'hE, 15);
    n = cyc;
    expectEvent(n + 10, 4'h0, 4'h1, 4'hF, 1'b0);
    applyStimulus(4'hF, 20);

    // Minimum-latency build: one-cycle low on key 3 commits two edges later, then releases.
    n = cyc;
    e.cyc = n + 3; e.press = 4'h8; e.rel = 4'h0; e.state = 4'h7; e.any = 1'b1;
    sb1.push_back(e);
    e.cyc = n + 4; e.press = 4'h0; e.rel = 4'h8; e.state = 4'hF; e.any = 1'b0;
    sb1.push_back(e);
    raw1 = 4'h7;
    @(negedge clk);
    raw1 = 4'hF;
    repeat (10) @(negedge clk);
    checkOutput("dut1 final key_state_n", int'(state1), 'hF);

    repeat (5) @(negedge clk);
    checkOutput("dut scoreboard drained", sb0.size(), 0);
    checkOutput("dut1 scoreboard drained", sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Per-key synchronizer and debouncer placed directly upstream of the 4-bit key PIO.
- Takes the raw, bouncing, active-low push-button pins and produces a clean debounced level bus that drives the PIO's `in_port`, so each physical press or release raises exactly one edge_capture event.
- Also emits one-cycle press/release strobes for fabric-side consumers that bypass the HPS.

Parameters:
- WIDTH, 4, number of independent keys.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required before accepting a new level (20 ms at 50 MHz). Must be >= 1.
- CNT_WIDTH, 20, width of each per-key stability counter. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- key_raw_n  input  WIDTH  asynchronous raw key pins, 0 = pressed.
- key_state_n  output  WIDTH  debounced level, 0 = pressed; connects to the PIO `in_port`.
- press_pulse  output  WIDTH  one-cycle strobe per key on an accepted 1->0 transition.
- release_pulse  output  WIDTH  one-cycle strobe per key on an accepted 0->1 transition.
- any_pressed  output  1  registered OR of ~key_state_n.

Behaviour:
- One clock and one reset. Reset is synchronous and active-high.
- Reset values (on any clk edge with reset=1):
  - sync1, sync2 = all 1s.
  - key_state_n = all 1s (released).
  - All counters = 0.
  - press_pulse, release_pulse = 0.
  - any_pressed = 0.
- Synchronizer: two-flop chain per bit, `sync1 <= key_raw_n` then `sync2 <= sync1`. No logic between the flops.
- Per key i, evaluated each edge when reset=0:
  - If `sync2[i] == key_state_n[i]`: `cnt[i] <= 0`. No state change.
  - If they differ and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - If they differ and `cnt[i] == DEBOUNCE_CYCLES-1`:
    - `key_state_n[i] <= sync2[i]` and `cnt[i] <= 0`.
    - `press_pulse[i] <= 1` if `sync2[i]` is 0, else `release_pulse[i] <= 1`.
  - In every other case the pulses are 0 on the next cycle. Pulses are never wider than one cycle.
- Equivalent per-key FSM:
  - STABLE (cnt=0, input matches state).
  - PENDING (counting; input differs from state).
  - PENDING returns to STABLE on a mismatch-clear, or commits on terminal count.
- Latency: a raw change that is stable before edge E0 appears on sync2 after edge E0+1. key_state_n and the corresponding pulse update at edge E0+1+DEBOUNCE_CYCLES.
  - With DEBOUNCE_CYCLES=1 this is 2 edges after E0 (sync latency plus one).
- Glitch rejection: any return of sync2 to the current state before terminal count clears the counter. The count restarts from 0 on the next mismatch; there is no accumulation across bounces.
- Keys are fully independent. Simultaneous transitions on several keys may commit in the same cycle, with multiple pulse bits set together.
- any_pressed is registered from the next-state key_state_n, so it updates in the same cycle as key_state_n.
- Reset mid-count: the counter is discarded and the state returns to released. A key held down through reset re-commits as pressed DEBOUNCE_CYCLES+2 edges after reset deasserts, generating a press_pulse.
- Counters never wrap; the maximum value reached is DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=8, WIDTH=4):
- Reset, key_raw_n=4'hF held -> key_state_n=4'hF, pulses=0, any_pressed=0 indefinitely.
- key_raw_n[0] driven 1->0 before edge E0 and held -> key_state_n=4'hE and press_pulse=4'h1 exactly at edge E0+9 for one cycle; any_pressed=1 from the same edge.
- Bounce on key 1: toggles low 5 cycles, high 2, low 3, then high -> no change on key_state_n and no pulses.
- Keys 2 and 3 pressed in the same cycle, then released 20 cycles later -> press_pulse=4'hC for one cycle, later release_pulse=4'hC for one cycle; key_state_n returns to 4'hF.
- Key 0 held low, reset asserted for 3 cycles mid-count and again after commit -> outputs return to reset values. After deassertion, press_pulse[0] fires at edge 10 after reset falls.
- DEBOUNCE_CYCLES=1 build: a single-cycle-stable change on key 3 commits 2 edges after the raw change.
